molecule_side_counter: RTL
==========================

// Module: molecule_side_counter
// PURPOSE
// - Downstream consumer of the molecule motion/pixel stages. Once per frame, scans every molecule's
//   (pos_x, pos_y, is_red) and counts red/blue molecules on each side of the membrane.
// - Publishes per-side counts and an equilibrium flag to the HUD/score logic.
// - Scan is sequential, one molecule per clk, so the comparator/adder cost stays constant with N_MOL.
// PARAMETERS
// - N_MOL      4    number of molecules on the input buses
// - MOL_SIZE   16   molecule square edge in pixels; centre = pos_x + MOL_SIZE/2
// - MEMBRANE_X 320  membrane column; centre < MEMBRANE_X => left, else right
// - EQ_TOL     0    max |left_total - right_total| counted as balanced
// - EQ_FRAMES  3    consecutive balanced scans required to raise equilibrium (>=1)
// PORTS
// - clk            in   1         system clock
// - reset          in   1         synchronous, active-high reset
// - frame          in   1         one-cycle pulse per video frame; starts a scan
// - freeze         in   1         1: frame pulses ignored, all outputs hold
// - pos_x_bus      in   10*N_MOL  molecule i x at [10i+9:10i]
// - pos_y_bus      in   10*N_MOL  molecule i y; carried only, not used for side decision
// - is_red_bus     in   N_MOL     1=red molecule, 0=blue
// - left_red       out  CW        CW=$clog2(N_MOL+1); red count left of membrane
// - right_red      out  CW        red count right of membrane
// - left_blue      out  CW        blue count left of membrane
// - right_blue     out  CW        blue count right of membrane
// - counts_valid   out  1         one-cycle pulse when count outputs update
// - equilibrium    out  1         balanced for >= EQ_FRAMES consecutive scans
// - frame_overrun  out  1         sticky: a frame pulse arrived while busy
// - crossings      out  16        saturating membrane-crossing count (see CONFIGURATION)
// BEHAVIOUR
// - Reset: all outputs 0, accumulators 0, idx 0, streak 0, FSM=IDLE. Reset mid-scan aborts the scan
//   with no counts_valid.
// - FSM IDLE -> SCAN on (frame & ~freeze): clear accumulators, idx=0.
// - SCAN, each cycle: centre = {1'b0,x_i} + MOL_SIZE/2 (11-bit, no wrap).
//   Increment exactly one of the 4 accumulators.
//   idx==N_MOL-1 -> DONE, else idx+1.
// - Input buses are sampled live during SCAN; upstream holds positions between frame pulses.
// - DONE (1 cycle): copy accumulators to outputs, pulse counts_valid, update streak/equilibrium,
//   then go to IDLE.
// - Latency: frame in cycle T -> counts_valid and new counts in cycle T+N_MOL+1.
// - frame in SCAN/DONE: dropped, frame_overrun<=1 until reset. A frame in the same cycle as the
//   DONE->IDLE transition is dropped.
// - freeze in SCAN/DONE: current scan completes normally; freeze only gates scan start.
// - Balance: L=left_red+left_blue, R=right_red+right_blue; balanced if |L-R|<=EQ_TOL.
//   Use CW+1-bit unsigned difference, no underflow.
// - Streak: balanced -> streak=min(streak+1,EQ_FRAMES); unbalanced -> streak=0.
//   equilibrium = (streak==EQ_FRAMES), registered in DONE.
// - Count outputs change only in DONE; stable otherwise.
// CONFIGURATION
// - MOL_CROSSING_COUNT_EN defined:
//   - Store a per-molecule side bit plus a seen flag, updated in SCAN.
//   - crossings += 1 for each molecule whose side differs from its previous scan; saturates at 16'hFFFF.
//   - First scan after reset only records sides and adds no crossings.
// - MOL_CROSSING_COUNT_EN undefined: no side storage, crossings tied to 16'd0.
// TESTING (N_MOL=4, MOL_SIZE=16, MEMBRANE_X=320, EQ_TOL=0, EQ_FRAMES=3)
// - Reset 2 cycles -> all outputs 0, counts_valid never pulses without frame.
// - x={100,400,300,312}, red={1,1,0,0}, frame@T -> counts_valid@T+5; left_red=1, right_red=1,
//   left_blue=1, right_blue=1 (312+8=320 -> right).
// - Second frame at T+2 -> ignored, frame_overrun=1, single counts_valid@T+5, counts unchanged.
// - Balanced 2/2 for 3 scans -> equilibrium 0,0,1; 4th scan x all 100 -> equilibrium 0.
//   freeze=1 with frame -> no scan.
// - Reset asserted at T+2 of a scan -> outputs 0, FSM IDLE, no counts_valid; next frame scans cleanly.
// - MOL_CROSSING_COUNT_EN: scan, move mol0 x 100->400, scan -> crossings=1;
//   without macro crossings=0.

Source files
------------

// File: rtl/molecule_side_counter.sv
// Once-per-frame sequential scan that counts red/blue molecules on each side of the membrane.
// Optional feature macro: MOL_CROSSING_COUNT_EN (saturating membrane-crossing counter).
module molecule_side_counter #(
    parameter int unsigned N_MOL      = 4,
    parameter int unsigned MOL_SIZE   = 16,
    parameter int unsigned MEMBRANE_X = 320,
    parameter int unsigned EQ_TOL     = 0,
    parameter int unsigned EQ_FRAMES  = 3,
    localparam int unsigned CW        = $clog2(N_MOL + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame,
    input  logic                 freeze,
    input  logic [10*N_MOL-1:0]  pos_x_bus,
    input  logic [10*N_MOL-1:0]  pos_y_bus,
    input  logic [N_MOL-1:0]     is_red_bus,
    output logic [CW-1:0]        left_red,
    output logic [CW-1:0]        right_red,
    output logic [CW-1:0]        left_blue,
    output logic [CW-1:0]        right_blue,
    output logic                 counts_valid,
    output logic                 equilibrium,
    output logic                 frame_overrun,
    output logic [15:0]          crossings
);
    localparam int unsigned IW = (N_MOL > 1) ? $clog2(N_MOL) : 1;
    localparam int unsigned SW = $clog2(EQ_FRAMES + 1);
    localparam int unsigned DW = CW + 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   idx;
    logic [CW-1:0]   acc_lr, acc_rr, acc_lb, acc_rb;
    logic [CW-1:0]   nxt_lr, nxt_rr, nxt_lb, nxt_rb;
    logic [SW-1:0]   streak;
    logic [SW-1:0]   streak_nxt;
    logic [9:0]      x_cur;
    logic [10:0]     centre;
    logic            is_right;
    logic            red_cur;
    logic            start;
    logic            last;
    logic [DW-1:0]   tot_l, tot_r, diff;
    logic            balanced;
    logic            unused_pos_y;

    // y position rides along the bus but never affects the side decision
    assign unused_pos_y = ^pos_y_bus;

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic; freeze only gates the start of a scan
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (frame && !freeze) begin
                    start     = 1'b1;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (idx == IW'(N_MOL - 1)) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // side classification of the molecule under the scan pointer
    always_comb begin
        x_cur    = pos_x_bus[10*32'(idx) +: 10];
        red_cur  = is_red_bus[idx];
        centre   = {1'b0, x_cur} + 11'(MOL_SIZE / 2);
        is_right = (centre >= 11'(MEMBRANE_X));
        nxt_lr   = acc_lr + CW'(red_cur & ~is_right);
        nxt_rr   = acc_rr + CW'(red_cur & is_right);
        nxt_lb   = acc_lb + CW'(~red_cur & ~is_right);
        nxt_rb   = acc_rb + CW'(~red_cur & is_right);
    end

    // balance and streak evaluated on the completed counts
    always_comb begin
        tot_l    = {1'b0, nxt_lr} + {1'b0, nxt_lb};
        tot_r    = {1'b0, nxt_rr} + {1'b0, nxt_rb};
        diff     = (tot_l >= tot_r) ? (tot_l - tot_r) : (tot_r - tot_l);
        balanced = (32'(diff) <= EQ_TOL);
        if (!balanced) begin
            streak_nxt = '0;
        end else if (streak == SW'(EQ_FRAMES)) begin
            streak_nxt = streak;
        end else begin
            streak_nxt = streak + SW'(1);
        end
    end

    // accumulators, scan pointer and published outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            idx           <= '0;
            acc_lr        <= '0;
            acc_rr        <= '0;
            acc_lb        <= '0;
            acc_rb        <= '0;
            streak        <= '0;
            left_red      <= '0;
            right_red     <= '0;
            left_blue     <= '0;
            right_blue    <= '0;
            counts_valid  <= 1'b0;
            equilibrium   <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            counts_valid <= last;
            if (frame && (state != IDLE)) begin
                frame_overrun <= 1'b1;
            end
            if (start) begin
                idx    <= '0;
                acc_lr <= '0;
                acc_rr <= '0;
                acc_lb <= '0;
                acc_rb <= '0;
            end else if (state == SCAN) begin
                idx    <= last ? '0 : idx + IW'(1);
                acc_lr <= nxt_lr;
                acc_rr <= nxt_rr;
                acc_lb <= nxt_lb;
                acc_rb <= nxt_rb;
            end
            // registering on the final scan edge makes the DONE cycle carry the new counts
            if (last) begin
                left_red    <= nxt_lr;
                right_red   <= nxt_rr;
                left_blue   <= nxt_lb;
                right_blue  <= nxt_rb;
                streak      <= streak_nxt;
                equilibrium <= (streak_nxt == SW'(EQ_FRAMES));
            end
        end
    end

`ifdef MOL_CROSSING_COUNT_EN
    logic [N_MOL-1:0] side_q;
    logic [N_MOL-1:0] seen_q;

    // per-molecule side history; first sighting only records the side
    always_ff @(posedge clk) begin
        if (reset) begin
            side_q    <= '0;
            seen_q    <= '0;
            crossings <= '0;
        end else if (state == SCAN) begin
            side_q[idx] <= is_right;
            seen_q[idx] <= 1'b1;
            if (seen_q[idx] && (side_q[idx] != is_right) && (crossings != 16'hFFFF)) begin
                crossings <= crossings + 16'd1;
            end
        end
    end
`else
    assign crossings = 16'd0;
`endif

endmodule
